riscv_lsu: RTL and testbench
============================

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 Parameter: TIMEOUT, 16, max cycles spent in REQ+WAIT before abort (range 2..255).
REQ-002 Port: CLK  input  1  system clock; all state changes on rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: lsu_req_i  input  1  core requests a memory access (decoder mem_req).
REQ-005 Port: lsu_we_i  input  1  1 = store, 0 = load.
REQ-006 Port: lsu_size_i  input  3  RISC-V funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-007 Port: lsu_addr_i  input  32  byte address (ALU result).
REQ-008 Port: lsu_data_i  input  32  store data (rs2).
REQ-009 Port: lsu_data_o  output  32  formatted load data to writeback mux.
REQ-010 Port: lsu_stall_o  output  1  1 = hold PC and register-file write.
REQ-011 Port: lsu_err_o  output  1  one-cycle pulse: misaligned, illegal size or timeout.
REQ-012 Port: mem_req_o, mem_we_o  output  1 each  memory request / write strobe.
REQ-013 Port: mem_be_o  output  4  byte enables.
REQ-014 Port: mem_addr_o, mem_wd_o  output  32 each  word-aligned address, lane-replicated write data.
REQ-015 Port: mem_gnt_i, mem_rvalid_i  input  1 each  request accepted / read data valid.
REQ-016 Port: mem_rd_i  input  32  memory read word.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-018 IDLE, lsu_req_i=1, access legal: latch we/size/addr/data, lsu_stall_o=1 combinationally, next state REQ.
REQ-019 Illegal: size in {3,6,7}, or H/HU/SH with addr[0]=1, or W with addr[1:0]!=0; SHALL pulse lsu_err_o same cycle, stall=0, no memory request, stay IDLE.
REQ-020 REQ: mem_req_o=1 with stable latched outputs, stall=1; on mem_gnt_i store -> DONE, load -> WAIT.
REQ-021 WAIT: stall=1, mem_req_o=0; on mem_rvalid_i register formatted data, -> DONE.
REQ-022 DONE: stall=0 for exactly one cycle, lsu_data_o valid, -> IDLE; lsu_req_i ignored in DONE.
REQ-023 mem_rvalid_i outside WAIT, or mem_gnt_i outside REQ, SHALL be ignored.
REQ-024 mem_addr_o = {latched_addr[31:2], 2'b00}.
REQ-025 Byte enables: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111.
REQ-026 mem_wd_o: B byte[7:0] replicated x4; H half[15:0] replicated x2; W unchanged.
REQ-027 Load extract lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-028 Timeout counter cleared on leaving IDLE, +1 per cycle in REQ/WAIT; at TIMEOUT-1 without completion -> DONE, lsu_err_o pulse in DONE, lsu_data_o=0.
REQ-029 Completion on the timeout cycle SHALL win over timeout (no error).
REQ-030 lsu_data_o SHALL hold its value until the next load completes.

Reset
REQ-031 RESET=1 SHALL force IDLE next edge, counter 0, lsu_data_o 0, all latched fields 0.
REQ-032 During reset and the cycle after: mem_req_o, mem_we_o, lsu_stall_o, lsu_err_o = 0; mem_be_o = 0.
REQ-033 Reset mid-transaction SHALL abort; later gnt/rvalid for it ignored.

Verification
REQ-034 SW addr 0x104, data 0xDEADBEEF, gnt after 2 cycles -> be 1111, addr 0x104, wd 0xDEADBEEF, stall 3 cycles then 0 in DONE.
REQ-035 LB addr 0x203, mem_rd 0x80FF0000, rvalid 1 cycle after gnt -> lsu_data_o 0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SH addr 0x12, data 0x0000ABCD -> be 1100, wd 0xABCDABCD; LHU addr 0x12, rd 0xABCD1234 -> 0x0000ABCD.
REQ-037 LW addr 0x101 -> err pulse same cycle, stall 0, mem_req_o never asserted.
REQ-038 Load, gnt given, no rvalid, TIMEOUT=16 -> DONE after 16 cycles, err pulse, data 0.
REQ-039 RESET asserted in WAIT, rvalid next cycle -> state IDLE, lsu_data_o 0, no err, no stall.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: RISC-V load/store unit with lane steering, extension and timeout abort
module riscv_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rd_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_n;
  logic we_q, to_q, legal, busy, expire, done_ok, stall, err, mreq;
  logic [2:0] size_q;
  logic [31:0] addr_q, data_q, lane, fmt;
  logic [7:0] cnt;
  logic [3:0] be;
  assign legal = !(lsu_size_i == 3'd3 || lsu_size_i >= 3'd6)
              && !(lsu_size_i[1:0] == 2'd1 && lsu_addr_i[0])
              && !(lsu_size_i == 3'd2 && lsu_addr_i[1:0] != 2'd0);
  assign busy = state == REQ || state == WAIT;
  assign expire = cnt == 8'(TIMEOUT - 1);
  assign done_ok = state == REQ ? mem_gnt_i && we_q : state == WAIT && mem_rvalid_i;
  assign lane = mem_rd_i >> {addr_q[1:0], 3'b000};
  assign fmt = size_q == 3'd0 ? {{24{lane[7]}}, lane[7:0]}
             : size_q == 3'd4 ? {24'b0, lane[7:0]}
             : size_q == 3'd1 ? {{16{lane[15]}}, lane[15:0]}
             : size_q == 3'd5 ? {16'b0, lane[15:0]}
             : mem_rd_i;
  assign be = size_q[1:0] == 2'd2 ? 4'b1111
            : size_q[0] ? 4'b0011 << {addr_q[1], 1'b0}
            : 4'b0001 << addr_q[1:0];
  always_comb begin
    state_n = state;
    stall = 1'b0;
    err = 1'b0;
    mreq = 1'b0;
    case (state)
      IDLE: begin
        stall = lsu_req_i && legal;
        err = lsu_req_i && !legal;
        state_n = lsu_req_i && legal ? REQ : IDLE;
      end
      REQ: begin
        stall = 1'b1;
        mreq = 1'b1;
        state_n = done_ok || expire ? DONE : mem_gnt_i ? WAIT : REQ;
      end
      WAIT: begin
        stall = 1'b1;
        state_n = done_ok || expire ? DONE : WAIT;
      end
      DONE: begin
        err = to_q;
        state_n = IDLE;
      end
    endcase
  end
  // outputs are forced quiet while reset is held, whatever the stale state says
  assign lsu_stall_o = stall && !RESET;
  assign lsu_err_o = err && !RESET;
  assign mem_req_o = mreq && !RESET;
  assign mem_we_o = mreq && we_q && !RESET;
  assign mem_be_o = mreq && !RESET ? be : 4'b0000;
  assign mem_addr_o = {addr_q[31:2], 2'b00};
  assign mem_wd_o = size_q[1:0] == 2'd0 ? {4{data_q[7:0]}}
                  : size_q[1:0] == 2'd1 ? {2{data_q[15:0]}}
                  : data_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= 8'd0;
      to_q <= 1'b0;
      we_q <= 1'b0;
      size_q <= 3'd0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
      lsu_data_o <= 32'd0;
    end else begin
      state <= state_n;
      cnt <= busy ? cnt + 8'd1 : 8'd0;
      to_q <= busy && expire && !done_ok;
      if (state == IDLE && lsu_req_i && legal) begin
        we_q <= lsu_we_i;
        size_q <= lsu_size_i;
        addr_q <= lsu_addr_i;
        data_q <= lsu_data_i;
      end
      if (state == WAIT && mem_rvalid_i)
        lsu_data_o <= fmt;
      else if (busy && expire && !done_ok)
        lsu_data_o <= 32'd0;
    end
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed transactions checked every cycle against a transaction-level model
module tb_riscv_lsu;
  localparam int T = 16;
  logic CLK = 1'b0, RESET;
  logic lsu_req_i, lsu_we_i, mem_gnt_i, mem_rvalid_i;
  logic [2:0] lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i, mem_rd_i;
  logic [31:0] lsu_data_o, mem_addr_o, mem_wd_o;
  logic lsu_stall_o, lsu_err_o, mem_req_o, mem_we_o;
  logic [3:0] mem_be_o;
  always #5 CLK = ~CLK;
  riscv_lsu #(.TIMEOUT(T)) dut (
    .CLK(CLK), .RESET(RESET), .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
    .lsu_size_i(lsu_size_i), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_data_o(lsu_data_o), .lsu_stall_o(lsu_stall_o), .lsu_err_o(lsu_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rd_i(mem_rd_i)
  );
  int n_chk = 0, n_fail = 0, req_cycles = 0, last_len, last_busy, r0;
  bit exp_on = 0, exp_stall, exp_err, exp_req, exp_we, exp_mem_on, exp_wd_on, last_to;
  logic [3:0] exp_be, last_be;
  logic [31:0] exp_addr, exp_wd, exp_data, last_wd, last_addr;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  function automatic bit ref_legal(input logic [2:0] s, input logic [31:0] a);
    case (s)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return a[0] == 1'b0;
      3'd2: return a[1:0] == 2'd0;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [3:0] ref_be(input logic [2:0] s, input logic [31:0] a);
    if (s == 3'd2) return 4'b1111;
    if (s == 3'd1 || s == 3'd5) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b0001 << a[1:0];
  endfunction
  function automatic logic [31:0] ref_wd(input logic [2:0] s, input logic [31:0] d);
    if (s == 3'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (s == 3'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction
  function automatic logic [31:0] ref_load(input logic [2:0] s, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * a[1:0]);
    case (s)
      3'd0: return v[7] ? (v | 32'hFFFFFF00) : (v & 32'hFF);
      3'd4: return v & 32'hFF;
      3'd1: return v[15] ? (v | 32'hFFFF0000) : (v & 32'hFFFF);
      3'd5: return v & 32'hFFFF;
      default: return rd;
    endcase
  endfunction
  task automatic quiet_exp();
    exp_stall = 0; exp_err = 0; exp_req = 0; exp_we = 0; exp_be = 4'd0;
    exp_mem_on = 0; exp_wd_on = 0;
  endtask
  task automatic idle(input int k);
    repeat (k) begin
      @(posedge CLK); #1;
      lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
      quiet_exp();
    end
  endtask
  // one access: gdly = request cycles before grant, rdly = wait cycles before rvalid
  task automatic access(input bit we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d,
                        input int gdly, input int rdly, input logic [31:0] rd, input bit noise);
    bit ok, done, wt, to, g;
    int n, j;
    ok = ref_legal(sz, a);
    @(posedge CLK); #1;
    lsu_req_i = 1; lsu_we_i = we; lsu_size_i = sz; lsu_addr_i = a; lsu_data_i = d;
    mem_gnt_i = noise; mem_rvalid_i = noise; mem_rd_i = ~rd;
    quiet_exp(); exp_stall = ok; exp_err = !ok;
    last_len = 1; done = !ok; wt = 0; to = 0; n = 0; j = 0;
    while (!done) begin
      @(posedge CLK); #1;
      lsu_addr_i = ~a; lsu_data_i = ~d; lsu_we_i = !we;
      quiet_exp(); exp_stall = 1; last_len++;
      if (!wt) begin
        g = n == gdly;
        mem_gnt_i = g; mem_rvalid_i = noise; mem_rd_i = ~rd;
        exp_req = 1; exp_we = we; exp_be = ref_be(sz, a); exp_addr = {a[31:2], 2'b00};
        exp_wd = ref_wd(sz, d); exp_mem_on = 1; exp_wd_on = we;
        last_be = exp_be; last_wd = exp_wd; last_addr = exp_addr;
        if (g && we) done = 1;
        else if (n == T - 1) begin done = 1; to = 1; end
        else if (g) wt = 1;
      end else begin
        g = j == rdly;
        mem_rvalid_i = g; mem_gnt_i = noise; mem_rd_i = g ? rd : ~rd;
        if (g) done = 1;
        else if (n == T - 1) begin done = 1; to = 1; end
        j++;
      end
      n++;
    end
    last_busy = n; last_to = to;
    @(posedge CLK); #1;
    mem_gnt_i = noise; mem_rvalid_i = noise; mem_rd_i = ~rd;
    quiet_exp();
    if (!ok) lsu_req_i = 0;
    else begin
      exp_err = to;
      if (to) exp_data = 32'd0;
      else if (!we) exp_data = ref_load(sz, a, rd);
    end
  endtask
  always @(negedge CLK) begin
    if (mem_req_o === 1'b1) req_cycles++;
    if (exp_on) begin
      chk("stall", 32'(lsu_stall_o), 32'(exp_stall));
      chk("err", 32'(lsu_err_o), 32'(exp_err));
      chk("mem_req", 32'(mem_req_o), 32'(exp_req));
      chk("mem_we", 32'(mem_we_o), 32'(exp_we));
      chk("mem_be", 32'(mem_be_o), 32'(exp_be));
      chk("lsu_data", lsu_data_o, exp_data);
      if (exp_mem_on) chk("mem_addr", mem_addr_o, exp_addr);
      if (exp_wd_on) chk("mem_wd", mem_wd_o, exp_wd);
    end
  end
  initial begin
    RESET = 1; lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = 0; lsu_addr_i = 0; lsu_data_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rd_i = 0;
    @(posedge CLK); #1;
    quiet_exp(); exp_data = 32'd0; exp_on = 1;
    @(posedge CLK); #1;
    RESET = 0;
    idle(1);
    access(1, 3'd2, 32'h104, 32'hDEADBEEF, 1, 0, 32'h0, 0);
    chk("sw_stall_len", 32'(last_len), 32'd3);
    chk("sw_be", 32'(last_be), 32'hF);
    chk("sw_addr", last_addr, 32'h104);
    chk("sw_wd", last_wd, 32'hDEADBEEF);
    idle(1);
    access(0, 3'd0, 32'h203, 32'h0, 0, 0, 32'h80FF0000, 0);
    chk("lb_data", lsu_data_o, 32'hFFFFFF80);
    access(0, 3'd4, 32'h203, 32'h0, 0, 0, 32'h80FF0000, 0);
    chk("lbu_data", lsu_data_o, 32'h00000080);
    access(1, 3'd1, 32'h12, 32'h0000ABCD, 0, 0, 32'h0, 1);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wd", last_wd, 32'hABCDABCD);
    access(0, 3'd5, 32'h12, 32'h0, 0, 0, 32'hABCD1234, 1);
    chk("lhu_data", lsu_data_o, 32'h0000ABCD);
    access(1, 3'd2, 32'h300, 32'h11223344, 0, 0, 32'h0, 0);
    chk("hold_after_store", lsu_data_o, 32'h0000ABCD);
    r0 = req_cycles;
    access(0, 3'd2, 32'h101, 32'h0, 0, 0, 32'h0, 0);
    access(0, 3'd3, 32'h100, 32'h0, 0, 0, 32'h0, 1);
    access(0, 3'd6, 32'h100, 32'h0, 0, 0, 32'h0, 0);
    access(0, 3'd1, 32'h11, 32'h0, 0, 0, 32'h0, 0);
    access(1, 3'd1, 32'h13, 32'h0, 0, 0, 32'h0, 0);
    idle(1);
    chk("illegal_no_req", 32'(req_cycles), 32'(r0));
    access(0, 3'd1, 32'h2, 32'h0, 1, 2, 32'h80010000, 1);
    chk("lh_data", lsu_data_o, 32'hFFFF8001);
    access(1, 3'd0, 32'h7, 32'h5A, 0, 0, 32'h0, 0);
    chk("sb_be", 32'(last_be), 32'h8);
    chk("sb_wd", last_wd, 32'h5A5A5A5A);
    access(0, 3'd2, 32'h80, 32'h0, 0, 99, 32'h1, 0);
    chk("ld_timeout_busy", 32'(last_busy), 32'd16);
    chk("ld_timeout_flag", 32'(last_to), 32'd1);
    chk("ld_timeout_data", lsu_data_o, 32'd0);
    access(1, 3'd2, 32'h8C, 32'h5, 99, 0, 32'h0, 0);
    chk("st_timeout_flag", 32'(last_to), 32'd1);
    access(0, 3'd2, 32'h84, 32'h0, 0, 14, 32'h13579BDF, 0);
    chk("edge_done_wins", 32'(last_to), 32'd0);
    chk("edge_done_data", lsu_data_o, 32'h13579BDF);
    access(1, 3'd2, 32'h88, 32'h7, 15, 0, 32'h0, 0);
    chk("edge_store_wins", 32'(last_to), 32'd0);
    access(0, 3'd2, 32'h40, 32'h0, 3, 1, 32'hCAFEF00D, 1);
    chk("lw_data", lsu_data_o, 32'hCAFEF00D);
    @(posedge CLK); #1;
    lsu_req_i = 1; lsu_we_i = 0; lsu_size_i = 3'd2; lsu_addr_i = 32'h44; mem_gnt_i = 0; mem_rvalid_i = 0;
    quiet_exp(); exp_stall = 1;
    @(posedge CLK); #1;
    lsu_req_i = 0; mem_gnt_i = 1;
    quiet_exp(); exp_stall = 1; exp_req = 1; exp_be = 4'hF; exp_addr = 32'h44; exp_mem_on = 1;
    @(posedge CLK); #1;
    mem_gnt_i = 0;
    quiet_exp(); exp_stall = 1;
    @(posedge CLK); #1;
    RESET = 1;
    quiet_exp();
    @(posedge CLK); #1;
    RESET = 0; mem_rvalid_i = 1; mem_rd_i = 32'h12345678;
    quiet_exp(); exp_data = 32'd0;
    idle(2);
    chk("reset_clears_data", lsu_data_o, 32'd0);
    exp_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
